// File: rtl/isa_pic_if.sv
// isa_pic_if: ISA-side bus bundle for the isa_pic interrupt controller.
//   ISA_A[9:0]  I/O address         ISA_DIN[7:0]  write data
//   ISA_IOW     raw IOW#, low       ISA_IOR       raw IOR#, low
//   ISA_DACK2   raw INTA#, low      INT           interrupt request to CPU (ISA_DRQ2)
//   DOUT[7:0]   data for ISA_D      DOE           enables DOUT onto ISA_D
// master: the bus side (CPU/testbench); slave: the controller.
interface isa_pic_if;
  logic [9:0] ISA_A;
  logic [7:0] ISA_DIN;
  logic       ISA_IOW;
  logic       ISA_IOR;
  logic       ISA_DACK2;
  logic       INT;
  logic [7:0] DOUT;
  logic       DOE;

  modport master (
    output ISA_A, ISA_DIN, ISA_IOW, ISA_IOR, ISA_DACK2,
    input  INT, DOUT, DOE
  );

  modport slave (
    input  ISA_A, ISA_DIN, ISA_IOW, ISA_IOR, ISA_DACK2,
    output INT, DOUT, DOE
  );
endinterface

// File: rtl/isa_pic.sv
// isa_pic: fixed-priority 8-input interrupt controller (8259-lite).
// Latches IRQ_REQ rising edges into IRR, raises INT for the highest-priority
// unmasked request that outranks everything in service, answers INTA with a
// vector byte and decodes ports 20h/21h for ICW1/ICW2/ICW4, OCW1/2/3 and reads.
// Ports:
//   CLK         system clock
//   RST         asynchronous active-high reset
//   IRQ_REQ[7:0] request lines, bit 0 highest priority
//   bus         isa_pic_if.slave (address, data, strobes, INT, DOUT, DOE)
module isa_pic #(
  parameter logic [7:0] RESET_BASE = 8'h08
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] IRQ_REQ,
  isa_pic_if.slave   bus
);

  typedef enum logic [1:0] {StReady, StWaitIcw2, StWaitIcw4} state_e;

  // Strobe synchronisers (bit0 = s0, bit1 = s1, bit2 = s2) and address/data
  // pipelined to line up with the s1 sample of the strobes.
  logic [2:0] iow_s, ior_s, dack_s;
  logic [9:0] a_s0, a_s1;
  logic [7:0] din_s0, din_s1;

  state_e     state_q;
  logic       icw4_q;
  logic [7:0] base_q;
  logic [7:0] irr_q, isr_q, imr_q;
  logic [7:0] irr_d, isr_d;
  logic       rsel_q;     // 0: port 20h reads IRR, 1: reads ISR
  logic [7:0] req_q;
  logic       int_q, int_d;
  logic [7:0] dout_q;
  logic       doe_q;
  logic       iow_armed_q;

  function automatic logic [2:0] lowest_idx(input logic [7:0] v);
    lowest_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowest_idx = 3'(i);
    end
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      iow_s  <= 3'b000;
      ior_s  <= 3'b000;
      dack_s <= 3'b000;
      a_s0   <= '0;
      a_s1   <= '0;
      din_s0 <= '0;
      din_s1 <= '0;
    end else begin
      iow_s  <= {iow_s[1:0], bus.ISA_IOW};
      ior_s  <= {ior_s[1:0], bus.ISA_IOR};
      dack_s <= {dack_s[1:0], bus.ISA_DACK2};
      a_s0   <= bus.ISA_A;
      a_s1   <= a_s0;
      din_s0 <= bus.ISA_DIN;
      din_s1 <= din_s0;
    end
  end

  logic iow_rise, iow_fall, ior_rise, ior_fall, dack_rise, dack_fall;
  assign iow_fall  = iow_s[2] & ~iow_s[1];
  assign iow_rise  = ~iow_s[2] & iow_s[1];
  assign ior_fall  = ior_s[2] & ~ior_s[1];
  assign ior_rise  = ~ior_s[2] & ior_s[1];
  assign dack_fall = dack_s[2] & ~dack_s[1];
  assign dack_rise = ~dack_s[2] & dack_s[1];

  logic sel20, sel21;
  assign sel20 = (a_s1 == 10'h020);
  assign sel21 = (a_s1 == 10'h021);

  // A write needs a full strobe seen after reset; a strobe already low when
  // reset is released never produces a write on its trailing edge.
  logic wr_en, wr_icw1, wr_ocw2, wr_ocw3, wr_21;
  assign wr_en   = iow_rise & iow_armed_q;
  assign wr_icw1 = wr_en & sel20 & din_s1[4];
  assign wr_ocw2 = wr_en & sel20 & ~din_s1[4] & ~din_s1[3] & (state_q == StReady);
  assign wr_ocw3 = wr_en & sel20 & ~din_s1[4] & din_s1[3] & (state_q == StReady);
  assign wr_21   = wr_en & sel21;

  logic [7:0] pend, irq_rise;
  logic [2:0] pend_idx, isr_idx;
  assign pend     = irr_q & ~imr_q;
  assign pend_idx = lowest_idx(pend);
  assign isr_idx  = lowest_idx(isr_q);
  assign irq_rise = IRQ_REQ & ~req_q;

  // EOI works on the ISR value before this cycle's acknowledge; a request edge
  // arriving with the acknowledge of the same bit is kept in IRR.
  always_comb begin
    irr_d = irr_q;
    isr_d = isr_q;
    if (wr_icw1) begin
      irr_d = '0;
      isr_d = '0;
    end else if (wr_ocw2) begin
      if (din_s1[7:5] == 3'b001) begin
        isr_d[isr_idx] = 1'b0;
      end else if (din_s1[7:5] == 3'b011) begin
        isr_d[din_s1[2:0]] = 1'b0;
      end
    end
    if (dack_fall && (pend != 8'h00)) begin
      isr_d[pend_idx] = 1'b1;
      irr_d[pend_idx] = 1'b0;
    end
    irr_d = irr_d | irq_rise;
  end

  assign int_d = (pend != 8'h00) && ((isr_q == 8'h00) || (pend_idx < isr_idx));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StReady;
      icw4_q      <= 1'b0;
      base_q      <= {RESET_BASE[7:3], 3'b000};
      imr_q       <= '0;
      rsel_q      <= 1'b0;
      irr_q       <= '0;
      isr_q       <= '0;
      req_q       <= '0;
      int_q       <= 1'b0;
      dout_q      <= '0;
      doe_q       <= 1'b0;
      iow_armed_q <= 1'b0;
    end else begin
      req_q <= IRQ_REQ;
      irr_q <= irr_d;
      isr_q <= isr_d;
      int_q <= int_d;

      if (iow_fall) begin
        iow_armed_q <= 1'b1;
      end else if (iow_rise) begin
        iow_armed_q <= 1'b0;
      end

      if (wr_icw1) begin
        imr_q   <= '0;
        rsel_q  <= 1'b0;
        icw4_q  <= din_s1[0];
        state_q <= StWaitIcw2;
      end else begin
        if (wr_ocw3 && din_s1[1]) rsel_q <= din_s1[0];
        if (wr_21) begin
          case (state_q)
            StReady:    imr_q <= din_s1;
            StWaitIcw2: begin
              base_q  <= {din_s1[7:3], 3'b000};
              state_q <= icw4_q ? StWaitIcw4 : StReady;
            end
            default:    state_q <= StReady;
          endcase
        end
      end

      if (dack_fall) begin
        dout_q <= (pend != 8'h00) ? {base_q[7:3], pend_idx} : {base_q[7:3], 3'd7};
        doe_q  <= 1'b1;
      end else if (ior_fall && (sel20 || sel21)) begin
        dout_q <= sel21 ? imr_q : (rsel_q ? isr_q : irr_q);
        doe_q  <= 1'b1;
      end else if (ior_rise || dack_rise) begin
        doe_q <= 1'b0;
      end
    end
  end

  assign bus.INT  = int_q;
  assign bus.DOUT = dout_q;
  assign bus.DOE  = doe_q;

endmodule
